// File: rtl/cachewbbuf.sv
// Multi-entry writeback (victim) buffer between the D$ and the bus interface.
// Dirty lines enqueue in one cycle, coalesce by line address and drain to the bus beat by beat in FIFO order.
module cachewbbuf #(
    parameter int PA_BITS    = 56,
    parameter int LINELEN    = 512,
    parameter int BEATW      = 64,
    parameter int NUMENTRIES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              AllocValid,
    output logic                              AllocReady,
    input  logic [PA_BITS-1:0]                AllocAdr,
    input  logic [LINELEN-1:0]                AllocLine,
    input  logic [PA_BITS-1:0]                LookupAdr,
    output logic                              LookupHit,
    output logic [LINELEN-1:0]                LookupLine,
    output logic                              BusWrite,
    output logic [PA_BITS-1:0]                BusAdr,
    output logic [BEATW-1:0]                  BusWriteData,
    input  logic                              BusAck,
    input  logic                              FlushReq,
    output logic                              FlushDone,
    output logic                              Empty,
    output logic                              Full,
    output logic [$clog2(NUMENTRIES+1)-1:0]   Count
);

    localparam int OFFSETLEN    = $clog2(LINELEN/8);
    localparam int BEATSPERLINE = LINELEN/BEATW;
    localparam int BEATBITS     = $clog2(BEATSPERLINE);
    localparam int BYTEBITS     = $clog2(BEATW/8);
    localparam int TAGW         = PA_BITS - OFFSETLEN;
    localparam int PTRW         = $clog2(NUMENTRIES);
    localparam int CNTW         = $clog2(NUMENTRIES+1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_busWrite;
    logic [NUMENTRIES-1:0] r_valid;
    logic [TAGW-1:0]      r_tag  [NUMENTRIES];
    logic [LINELEN-1:0]   r_data [NUMENTRIES];
    logic [PTRW-1:0]      r_head;
    logic [PTRW-1:0]      r_tail;
    logic [CNTW-1:0]      r_count;
    logic [BEATBITS-1:0]  r_beat;

    logic [TAGW-1:0]      w_allocTag;
    logic [TAGW-1:0]      w_lookupTag;
    logic                 w_full;
    logic                 w_draining;
    logic                 w_allocFire;
    logic                 w_lastAck;
    logic                 w_push;
    logic                 w_coalHit;
    logic [PTRW-1:0]      w_coalIdx;
    logic [PTRW-1:0]      w_lkIdx;
    logic                 w_lookupHit;
    logic [LINELEN-1:0]   w_lookupLine;
    logic                 w_unused;

    assign w_allocTag  = AllocAdr[PA_BITS-1:OFFSETLEN];
    assign w_lookupTag = LookupAdr[PA_BITS-1:OFFSETLEN];
    assign w_unused    = ^{AllocAdr[OFFSETLEN-1:0], LookupAdr[OFFSETLEN-1:0]};
    assign w_full      = (r_count == CNTW'(NUMENTRIES));
    assign w_draining  = (r_state == S_DRAIN);
    assign w_allocFire = AllocValid & ~w_full;
    assign w_lastAck   = w_draining & BusAck & (r_beat == BEATBITS'(BEATSPERLINE-1));
    assign w_push      = w_allocFire & ~w_coalHit;

    // The head that is already bursting must not change under the bus, so it is excluded from coalescing.
    always_comb begin
        w_coalHit = 1'b0;
        w_coalIdx = '0;
        for (int i = 0; i < NUMENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == w_allocTag) &&
                !(w_draining && (PTRW'(i) == r_head))) begin
                w_coalHit = 1'b1;
                w_coalIdx = PTRW'(i);
            end
        end
    end

    // Walk from head toward tail so the newest matching copy wins.
    always_comb begin
        w_lookupHit  = 1'b0;
        w_lookupLine = '0;
        w_lkIdx      = r_head;
        for (int i = 0; i < NUMENTRIES; i++) begin
            w_lkIdx = r_head + PTRW'(i);
            if (r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lookupTag)) begin
                w_lookupHit  = 1'b1;
                w_lookupLine = r_data[w_lkIdx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_busWrite <= 1'b0;
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state    <= S_DRAIN;
                        r_busWrite <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (BusAck) begin
                        if (w_lastAck) begin
                            r_beat     <= '0;
                            r_state    <= S_IDLE;
                            r_busWrite <= 1'b0;
                        end else begin
                            r_beat <= r_beat + BEATBITS'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busWrite <= 1'b0;
                end
            endcase

            if (w_lastAck) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTRW'(1);
            end

            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTRW'(1);
            end

            case ({w_push, w_lastAck})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Line storage needs no reset; validity alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (w_allocFire) begin
            if (w_coalHit) begin
                r_data[w_coalIdx] <= AllocLine;
            end else begin
                r_tag[r_tail]  <= w_allocTag;
                r_data[r_tail] <= AllocLine;
            end
        end
    end

    assign AllocReady   = ~w_full;
    assign Full         = w_full;
    assign Empty        = (r_count == '0);
    assign Count        = r_count;
    assign FlushDone    = FlushReq & Empty;
    assign LookupHit    = w_lookupHit;
    assign LookupLine   = w_lookupLine;
    assign BusWrite     = r_busWrite;
    assign BusAdr       = {r_tag[r_head], r_beat, BYTEBITS'(0)};
    assign BusWriteData = r_data[r_head][r_beat*BEATW +: BEATW];

endmodule

// File: tb/tb_cachewbbuf.sv
// Self-checking bench for cachewbbuf: a scoreboard of expected lines checks every bus beat,
// while per-scenario tasks check status, lookup and flush behaviour inline.
module tb_cachewbbuf;

    localparam int PA = 56;
    localparam int LL = 512;
    localparam int BW = 64;
    localparam int NE = 4;
    localparam int CW = $clog2(NE+1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          AllocValid, AllocReady;
    logic [PA-1:0] AllocAdr;
    logic [LL-1:0] AllocLine;
    logic [PA-1:0] LookupAdr;
    logic          LookupHit;
    logic [LL-1:0] LookupLine;
    logic          BusWrite;
    logic [PA-1:0] BusAdr;
    logic [BW-1:0] BusWriteData;
    logic          BusAck;
    logic          FlushReq, FlushDone, Empty, Full;
    logic [CW-1:0] Count;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [PA-1:0] adr;
        logic [LL-1:0] data;
    } expLine_t;

    expLine_t      expLines[$];
    int            monBeat = 0;
    logic [PA-1:0] monAdr;
    logic [BW-1:0] monData;

    cachewbbuf #(.PA_BITS(PA), .LINELEN(LL), .BEATW(BW), .NUMENTRIES(NE)) dut (
        .clk(clk), .reset(reset),
        .AllocValid(AllocValid), .AllocReady(AllocReady), .AllocAdr(AllocAdr), .AllocLine(AllocLine),
        .LookupAdr(LookupAdr), .LookupHit(LookupHit), .LookupLine(LookupLine),
        .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWriteData(BusWriteData), .BusAck(BusAck),
        .FlushReq(FlushReq), .FlushDone(FlushDone), .Empty(Empty), .Full(Full), .Count(Count)
    );

    always #5 clk = ~clk;

    // Every presented beat must match the oldest expected line; an ack advances the scoreboard.
    always @(negedge clk) begin
        if (reset && BusWrite) begin
            testsRun++;
            if (expLines.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_beat: got BusWrite=1 adr=%h, want no beat", BusAdr);
            end else begin
                monAdr  = {expLines[0].adr[PA-1:6], 6'b0} + PA'(monBeat*8);
                monData = expLines[0].data[monBeat*BW +: BW];
                if (BusAdr !== monAdr || BusWriteData !== monData) begin
                    testsFailed++;
                    $display("[TB] FAIL beat%0d: got adr=%h data=%h, want adr=%h data=%h",
                             monBeat, BusAdr, BusWriteData, monAdr, monData);
                end
                if (BusAck) begin
                    monBeat++;
                    if (monBeat == LL/BW) begin
                        monBeat = 0;
                        void'(expLines.pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [LL-1:0] mkLine(input logic [31:0] seed);
        logic [LL-1:0] l;
        for (int k = 0; k < LL/BW; k++) l[k*BW +: BW] = {seed, 32'hC0DE_0000 | 32'(k)};
        return l;
    endfunction

    function automatic logic [LL-1:0] rampLine();
        logic [LL-1:0] l;
        for (int b = 0; b < LL/8; b++) l[b*8 +: 8] = 8'(b);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds AllocValid until the buffer has room, then records the line if it should drain on its own.
    task automatic applyAlloc(input logic [PA-1:0] adr, input logic [LL-1:0] line, input bit expectNew);
        int n = 0;
        AllocValid = 1'b1;
        AllocAdr   = adr;
        AllocLine  = line;
        while (AllocReady !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL alloc_timeout: got AllocReady=%b, want 1", AllocReady);
        end else if (expectNew) begin
            expLines.push_back('{adr, line});
        end
        tick();
        AllocValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expLines.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_timeout: got %0d lines pending, want 0", expLines.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick(); tick();
        testsRun++; if (Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d want 0", Count); end
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_empty: got %b want 1", Empty); end
        testsRun++; if (Full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_full: got %b want 0", Full); end
        testsRun++; if (AllocReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b want 1", AllocReady); end
        testsRun++; if (BusWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_buswrite: got %b want 0", BusWrite); end
        testsRun++; if (LookupHit !== 1'b0 || LookupLine !== '0) begin testsFailed++; $display("[TB] FAIL reset_lookup: got hit=%b want 0", LookupHit); end
        testsRun++; if (FlushDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flushdone: got %b want 0", FlushDone); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        BusAck = 1'b1;
        applyAlloc(56'h8000_0040, rampLine(), 1'b1);
        testsRun++; if (Count !== 3'd1 || Empty !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_count: got count=%0d empty=%b want 1/0", Count, Empty); end
        testsRun++; if (BusWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_latency1: got BusWrite=%b want 0", BusWrite); end
        tick();
        testsRun++; if (BusWrite !== 1'b1 || BusAdr !== 56'h8000_0040) begin testsFailed++; $display("[TB] FAIL single_first_beat: got bw=%b adr=%h want 1/80000040", BusWrite, BusAdr); end
        waitDrain();
        testsRun++; if (Count !== 3'd0 || Empty !== 1'b1 || BusWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_done: got count=%0d empty=%b bw=%b want 0/1/0", Count, Empty, BusWrite); end
    endtask

    task automatic test_full_wrap();
        BusAck = 1'b0;
        for (int i = 0; i < NE; i++) applyAlloc(56'h0001_0000 + PA'(i*64), mkLine(32'h100 + 32'(i)), 1'b1);
        testsRun++; if (Full !== 1'b1 || AllocReady !== 1'b0 || Count !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_flags: got full=%b ready=%b count=%0d want 1/0/4", Full, AllocReady, Count); end
        AllocValid = 1'b1;
        AllocAdr   = 56'h9000;
        AllocLine  = mkLine(32'h999);
        tick();
        AllocValid = 1'b0;
        testsRun++; if (Count !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_reject: got count=%0d want 4", Count); end
        BusAck = 1'b1;
        for (int i = 0; i < NE; i++) applyAlloc(56'h0003_0000 + PA'(i*64), mkLine(32'h200 + 32'(i)), 1'b1);
        waitDrain();
        testsRun++; if (Count !== 3'd0 || Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_done: got count=%0d empty=%b want 0/1", Count, Empty); end
    endtask

    task automatic test_coalesce();
        logic [LL-1:0] lineA, d1, d2, d3, d4;
        lineA = mkLine(32'hAAAA);
        d1 = mkLine(32'hD1); d2 = mkLine(32'hD2); d3 = mkLine(32'hD3); d4 = mkLine(32'hD4);
        BusAck = 1'b0;
        applyAlloc(56'h2000_0000, lineA, 1'b1);
        applyAlloc(56'h1000, d1, 1'b0);
        applyAlloc(56'h1000, d2, 1'b1);
        testsRun++; if (Count !== 3'd2) begin testsFailed++; $display("[TB] FAIL coalesce_count: got %0d want 2", Count); end
        LookupAdr = 56'h1010;
        #1;
        testsRun++; if (LookupHit !== 1'b1 || LookupLine !== d2) begin testsFailed++; $display("[TB] FAIL lookup_hit: got hit=%b line=%h want 1/%h", LookupHit, LookupLine, d2); end
        LookupAdr = 56'h2000_0008;
        #1;
        testsRun++; if (LookupHit !== 1'b1 || LookupLine !== lineA) begin testsFailed++; $display("[TB] FAIL lookup_head: got hit=%b line=%h want 1/%h", LookupHit, LookupLine, lineA); end
        LookupAdr = 56'h5000;
        #1;
        testsRun++; if (LookupHit !== 1'b0 || LookupLine !== '0) begin testsFailed++; $display("[TB] FAIL lookup_miss: got hit=%b line=%h want 0/0", LookupHit, LookupLine); end
        BusAck = 1'b1;
        waitDrain();
        testsRun++; if (Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL coalesce_drain: got empty=%b want 1", Empty); end

        BusAck = 1'b0;
        applyAlloc(56'h1000, d3, 1'b1);
        tick();
        testsRun++; if (BusWrite !== 1'b1) begin testsFailed++; $display("[TB] FAIL headdup_draining: got %b want 1", BusWrite); end
        applyAlloc(56'h1000, d4, 1'b1);
        testsRun++; if (Count !== 3'd2) begin testsFailed++; $display("[TB] FAIL headdup_count: got %0d want 2", Count); end
        LookupAdr = 56'h1000;
        #1;
        testsRun++; if (LookupHit !== 1'b1 || LookupLine !== d4) begin testsFailed++; $display("[TB] FAIL lookup_newer: got hit=%b line=%h want 1/%h", LookupHit, LookupLine, d4); end
        BusAck = 1'b1;
        waitDrain();
        testsRun++; if (Empty !== 1'b1 || Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL headdup_drain: got empty=%b count=%0d want 1/0", Empty, Count); end
    endtask

    // With ack held high: three 8-beat lines plus two idle bubbles empty the buffer after 26 edges.
    task automatic test_flush();
        BusAck   = 1'b0;
        FlushReq = 1'b0;
        for (int i = 0; i < 3; i++) applyAlloc(56'h0004_0000 + PA'(i*64), mkLine(32'h300 + 32'(i)), 1'b1);
        tick();
        FlushReq = 1'b1;
        #1;
        testsRun++; if (FlushDone !== 1'b0 || BusWrite !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_start: got done=%b bw=%b want 0/1", FlushDone, BusWrite); end
        BusAck = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            testsRun++;
            if (FlushDone !== (k >= 26)) begin
                testsFailed++;
                $display("[TB] FAIL flush_done_cycle%0d: got %b want %b", k, FlushDone, (k >= 26));
            end
        end
        FlushReq = 1'b0;
        testsRun++; if (expLines.size() != 0) begin testsFailed++; $display("[TB] FAIL flush_lines: got %0d pending want 0", expLines.size()); end
    endtask

    task automatic test_reset_mid();
        BusAck = 1'b1;
        applyAlloc(56'h7000_0000, mkLine(32'h77), 1'b1);
        tick();
        testsRun++; if (BusWrite !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_start: got %b want 1", BusWrite); end
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        testsRun++; if (BusWrite !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_abort: got bw=%b count=%0d empty=%b want 0/0/1", BusWrite, Count, Empty); end
        expLines.delete();
        monBeat = 0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        testsRun++; if (BusWrite !== 1'b0 || Count !== 3'd0) begin testsFailed++; $display("[TB] FAIL midreset_quiet: got bw=%b count=%0d want 0/0", BusWrite, Count); end
    endtask

    initial begin
        AllocValid = 1'b0;
        AllocAdr   = '0;
        AllocLine  = '0;
        LookupAdr  = 56'h1000;
        BusAck     = 1'b0;
        FlushReq   = 1'b0;
        test_reset();
        test_single();
        test_full_wrap();
        test_coalesce();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cachewbbuf.md
# cachewbbuf

Parametrised multi-entry writeback (victim) buffer between the D$ and the bus interface. Generalises the cache's single blocking dirty-line writeback: evicted dirty lines are enqueued in one cycle so the cache can proceed with the line fill, then drained to the bus beat by beat in FIFO order. Lines already queued for the same address are coalesced in place. Lookups of queued lines are supported so that a miss refills from the buffer, not from stale memory.

## Interface
Parameters:
- PA_BITS, 56, physical address width
- LINELEN, 512, cache line width in bits
- BEATW, 64, bus data width per beat; LINELEN/BEATW = BEATSPERLINE, power of 2, ≥2
- NUMENTRIES, 4, buffered lines; power of 2, ≥2

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low (0 = reset)
- AllocValid  input  1  cache presents an evicted dirty line
- AllocReady  output  1  buffer can accept; equals ~Full
- AllocAdr  input  PA_BITS  line address; offset bits ignored
- AllocLine  input  LINELEN  line data
- LookupAdr  input  PA_BITS  address probed by a cache miss
- LookupHit  output  1  a valid entry holds LookupAdr's line
- LookupLine  output  LINELEN  data of the hitting entry; 0 on miss
- BusWrite  output  1  write beat valid
- BusAdr  output  PA_BITS  beat address
- BusWriteData  output  BEATW  beat data
- BusAck  input  1  bus accepted current beat
- FlushReq  input  1  cache requests a full drain
- FlushDone  output  1  FlushReq & Empty
- Empty  output  1  no valid entries
- Full  output  1  Count == NUMENTRIES
- Count  output  $clog2(NUMENTRIES+1)  valid entry count

## Operation
- Storage: NUMENTRIES entries {valid, lineadr[PA_BITS-1:OFFSETLEN], data}. Circular head/tail pointers with wrap, plus Count.
- Alloc accepted iff AllocValid & AllocReady.
- Coalesce: if an accepted alloc matches a valid entry's lineadr and that entry is not the head in DRAIN, overwrite its data. Count and pointers are unchanged.
- Otherwise, write the entry at tail, set valid, advance tail, increment Count.
- A match against the head while DRAIN is active appends a new entry; ordering guarantees the newer data reaches memory last.
- Lookup: combinational match over valid entries. With two matches (draining head plus a newer entry), the newer one (closer to tail) wins.
- Drain FSM states:
  - IDLE → DRAIN when Count ≠ 0.
  - DRAIN: BusWrite = 1; BusAdr = {head lineadr, beat·BEATW/8}; BusWriteData = head data[beat·BEATW +: BEATW].
  - BusAck increments beat.
  - Ack on beat BEATSPERLINE-1: clear head valid, advance head, decrement Count, beat ← 0, → IDLE.
- Simultaneous alloc (non-coalescing) and final-beat pop: Count unchanged, both pointers advance.
- Full & final-beat pop in the same cycle: AllocReady stays 0. No same-cycle bypass.
- FlushReq does not change drain order; it only qualifies FlushDone.

## Timing
- Reset values: all valid = 0, head = tail = 0, Count = 0, Empty = 1, Full = 0, AllocReady = 1, BusWrite = 0, beat = 0, FSM IDLE, LookupHit = 0, FlushDone = 0.
- An accepted alloc is visible to Lookup, Count, Empty and Full the next cycle. With the FSM in IDLE, BusWrite rises 1 cycle after that (2 cycles after the alloc edge).
- Line drain takes BEATSPERLINE acked cycles minimum, plus one IDLE bubble between lines.
- BusAdr and BusWriteData stay stable while BusWrite = 1 & BusAck = 0.
- Reset asserted mid-drain aborts the burst: BusWrite = 0 the next cycle, all entries are dropped, and no further beats are issued.
- Lookup and FlushDone are combinational from registered state and same-cycle inputs.

## Test plan
- Single alloc of 0x8000_0040 (line bytes 0x00..0x3F) with BusAck tied 1 → 8 beats at 0x...40, 0x...48 … 0x...78 with matching data. Count returns to 0 and Empty = 1 after the last beat.
- Four allocs with BusAck = 0 → Full = 1, AllocReady = 0. A fifth AllocValid is not accepted. Release BusAck → lines drain in alloc order, with tail/head wrap exercised on a further four allocs.
- Re-alloc 0x1000 with new data while 0x1000 is queued but not at the draining head → Count unchanged, drained data equals the new data. Repeat while 0x1000 is the draining head → Count +1 and two bursts, newer data last.
- Lookup of a queued line → LookupHit = 1 with correct LookupLine. Lookup of an unqueued address → LookupHit = 0, LookupLine = 0. With head and newer duplicate both queued → the newer data is returned.
- FlushReq held with 3 entries queued → FlushDone = 0 until the cycle after the final beat ack, then 1.
- Reset = 0 during beat 3 of a burst → BusWrite = 0 next cycle, Count = 0, no beats issued after reset is released.
